// File: rtl/matrix_scan_capture_if.sv
// Scan-bus / readback bundle for matrix_scan_capture.
// master: the side driving the matrix pins and reading the frame.
// slave : the capture monitor.
interface matrix_scan_capture_if;
  logic        enable;
  logic [7:0]  dinor;
  logic [15:0] outc;
  logic [2:0]  rd_row;
  logic        err_clr;
  logic [15:0] rd_data;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        seq_err;
  logic        sel_err;
  logic        frame_blank;

  modport master (
    output enable, dinor, outc, rd_row, err_clr,
    input  rd_data, frame_done, frame_count, seq_err, sel_err, frame_blank
  );

  modport slave (
    input  enable, dinor, outc, rd_row, err_clr,
    output rd_data, frame_done, frame_count, seq_err, sel_err, frame_blank
  );
endinterface

// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture: rebuilds the 8x16 LED matrix frame from the observed
// active-low row select and column data, committing each complete in-order
// scan atomically to a readable buffer.
// Optional feature: define MATRIX_CAP_BLANK_DETECT_EN to enable frame_blank
// (all committed rows zero, updated at each commit); otherwise tied to 0.
module matrix_scan_capture #(
  parameter int unsigned SETTLE        = 1,
  parameter int unsigned BLANK_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  matrix_scan_capture_if.slave bus
);

  localparam logic [3:0] SETTLE_C     = 4'(SETTLE);
  localparam logic [7:0] TIMEOUT_LAST = 8'(BLANK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HUNT, ACQ} state_t;

  state_t      state_q, state_d;
  logic [7:0]  dinor_q;
  logic [15:0] outc_q;
  logic [3:0]  zeros;
  logic [2:0]  row;
  logic        row_valid, row_blank, row_illegal;
  logic [3:0]  stab_q, stab_d;
  logic [2:0]  prev_row_q;
  logic        same_row, capture;
  logic [7:0]  blank_q, blank_d;
  logic        timeout;
  logic [2:0]  exp_row_q, exp_row_d;
  logic        shadow_we, shadow_clr, commit, seq_set;
  logic [15:0] shadow_q   [8];
  logic [15:0] frame_q    [8];
  logic [15:0] next_frame [8];
  logic [15:0] rd_data_q;
  logic        frame_done_q;
  logic [7:0]  frame_count_q;
  logic        seq_err_q, sel_err_q;

  // Register the observed pins once; everything below decodes the copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dinor_q <= '1;
      outc_q  <= '0;
    end else begin
      dinor_q <= bus.dinor;
      outc_q  <= bus.outc;
    end
  end

  // Row decode: exactly one low bit is a valid row, all-ones is blank.
  always_comb begin
    zeros = '0;
    row   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!dinor_q[i]) begin
        zeros = zeros + 4'd1;
        row   = 3'(i);
      end
    end
  end

  assign row_valid   = (zeros == 4'd1);
  assign row_blank   = !row_valid;
  assign row_illegal = !row_valid && (dinor_q != '1);

  // Dwell counter saturates at SETTLE so a held row is captured only once.
  assign same_row = (stab_q != '0) && (row == prev_row_q);

  always_comb begin
    stab_d = '0;
    if (row_valid) begin
      if (!same_row)             stab_d = 4'd1;
      else if (stab_q == SETTLE_C) stab_d = stab_q;
      else                       stab_d = stab_q + 4'd1;
    end
  end

  assign capture = row_valid && (stab_d == SETTLE_C) && !(same_row && (stab_q == SETTLE_C));

  // Consecutive blank/illegal cycles while acquiring.
  assign blank_d = (state_q == ACQ && row_blank) ? blank_q + 8'd1 : '0;
  assign timeout = (state_q == ACQ) && row_blank && (blank_q == TIMEOUT_LAST);

  // Sequencer next-state and control strobes.
  always_comb begin
    state_d    = state_q;
    exp_row_d  = exp_row_q;
    shadow_we  = 1'b0;
    shadow_clr = 1'b0;
    commit     = 1'b0;
    seq_set    = 1'b0;
    if (!bus.enable) begin
      state_d    = IDLE;
      exp_row_d  = '0;
      shadow_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (capture && row == 3'd0) begin
            shadow_we = 1'b1;
            exp_row_d = 3'd1;
            state_d   = ACQ;
          end
        end
        ACQ: begin
          if (capture) begin
            if (row == exp_row_q) begin
              shadow_we = 1'b1;
              exp_row_d = exp_row_q + 3'd1;
              commit    = (row == 3'd7);
            end else begin
              seq_set = 1'b1;
              if (row == 3'd0) begin
                // Out-of-order row 0 restarts the frame immediately.
                shadow_we = 1'b1;
                exp_row_d = 3'd1;
              end else begin
                exp_row_d = '0;
                state_d   = HUNT;
              end
            end
          end else if (timeout) begin
            seq_set   = 1'b1;
            exp_row_d = '0;
            state_d   = HUNT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer state, expected row, dwell and blank counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      exp_row_q  <= '0;
      stab_q     <= '0;
      prev_row_q <= '0;
      blank_q    <= '0;
    end else begin
      state_q   <= state_d;
      exp_row_q <= exp_row_d;
      stab_q    <= stab_d;
      blank_q   <= blank_d;
      if (row_valid) prev_row_q <= row;
    end
  end

  // Shadow contents as they will be after this cycle's write.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++)
      next_frame[i] = (shadow_we && row == 3'(i)) ? outc_q : shadow_q[i];
  end

  // Shadow buffer collects the frame under construction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) shadow_q[i] <= '0;
    end else if (shadow_clr) begin
      for (int unsigned i = 0; i < 8; i++) shadow_q[i] <= '0;
    end else if (shadow_we) begin
      shadow_q[row] <= outc_q;
    end
  end

  // Committed buffer and registered read port; on the commit edge the read
  // is served from the incoming frame so new data appears without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) frame_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (commit) begin
        for (int unsigned i = 0; i < 8; i++) frame_q[i] <= next_frame[i];
        rd_data_q <= next_frame[bus.rd_row];
      end else begin
        rd_data_q <= frame_q[bus.rd_row];
      end
    end
  end

  // Commit pulse, frame counter and sticky error flags (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      seq_err_q     <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      frame_done_q <= commit;
      if (commit) frame_count_q <= frame_count_q + 8'd1;
      if (seq_set)          seq_err_q <= 1'b1;
      else if (bus.err_clr) seq_err_q <= 1'b0;
      if (row_illegal)      sel_err_q <= 1'b1;
      else if (bus.err_clr) sel_err_q <= 1'b0;
    end
  end

`ifdef MATRIX_CAP_BLANK_DETECT_EN
  logic frame_blank_q;
  logic next_zero;

  // All-zero detect over the frame being committed.
  always_comb begin
    next_zero = 1'b1;
    for (int unsigned i = 0; i < 8; i++)
      if (next_frame[i] != '0) next_zero = 1'b0;
  end

  // frame_blank holds its value between commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        frame_blank_q <= 1'b0;
    else if (commit) frame_blank_q <= next_zero;
  end

  assign bus.frame_blank = frame_blank_q;
`else
  assign bus.frame_blank = 1'b0;
`endif

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_count_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.sel_err     = sel_err_q;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Self-checking bench for matrix_scan_capture: dut_a (SETTLE=1) and
// dut_b (SETTLE=3). Frame commits are checked against a scoreboard queue.
module tb_matrix_scan_capture;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matrix_scan_capture_if ia ();
  matrix_scan_capture_if ib ();

  matrix_scan_capture #(.SETTLE(1), .BLANK_TIMEOUT(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  matrix_scan_capture #(.SETTLE(3), .BLANK_TIMEOUT(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  typedef struct {
    logic [7:0][15:0] rows;
    logic             blank;
  } frame_t;

  typedef struct {
    logic [7:0]  cnt;
    logic [15:0] row3;
    logic        blank;
  } exp_t;

  frame_t frames [5];
  exp_t   sb [$];
  exp_t   a_e;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;
  int last_row7_cyc = 0;
  int b_done_n = 0;
  int b_last_cyc = 0;
  logic [7:0] exp_cnt = '0;
  logic a_done_prev = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic blank_exp(input int f);
`ifdef MATRIX_CAP_BLANK_DETECT_EN
    return frames[f].blank;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_exp(input int f);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.cnt   = exp_cnt;
    e.row3  = frames[f].rows[3];
    e.blank = blank_exp(f);
    sb.push_back(e);
  endtask

  task automatic drv(input bit b, input logic [7:0] d, input logic [15:0] c);
    @(negedge clk);
    if (b) begin
      ib.dinor = d;
      ib.outc  = c;
    end else begin
      ia.dinor = d;
      ia.outc  = c;
      if (d == 8'h7F) last_row7_cyc = cyc_n;
    end
  endtask

  task automatic scan(input bit b, input int f, input int unsigned first, input int unsigned last,
                      input int unsigned hold);
    for (int unsigned r = first; r <= last; r++)
      for (int unsigned h = 0; h < hold; h++)
        drv(b, 8'(~(8'd1 << r)), frames[f].rows[r]);
  endtask

  task automatic idle(input bit b, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) drv(b, 8'hFF, 16'h0000);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ia.err_clr = 1'b1;
    @(negedge clk);
    ia.err_clr = 1'b0;
  endtask

  // Scoreboard monitor for dut_a commits.
  always @(negedge clk) begin
    if (ia.frame_done) begin
      check("a_done_width", 32'(a_done_prev), 32'd0);
      check("a_commit_latency", 32'(cyc_n - last_row7_cyc), 32'd2);
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL a_unexpected_done: got frame_done with frame_count %0d, expected no commit",
                 ia.frame_count);
      end else begin
        a_e = sb.pop_front();
        check("a_frame_count", 32'(ia.frame_count), 32'(a_e.cnt));
        check("a_rd_row3_at_commit", 32'(ia.rd_data), 32'(a_e.row3));
        check("a_frame_blank", 32'(ia.frame_blank), 32'(a_e.blank));
      end
    end
    a_done_prev = ia.frame_done;
  end

  // dut_b commit spacing.
  always @(negedge clk) begin
    if (ib.frame_done) begin
      if (b_done_n != 0) check("b_done_interval", 32'(cyc_n - b_last_cyc), 32'd24);
      b_done_n   = b_done_n + 1;
      b_last_cyc = cyc_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    frames[0].rows = {16'h0000, 16'h0000, 16'h0080, 16'h00C0, 16'h00E0, 16'h00C0, 16'h0080, 16'h0000};
    frames[0].blank = 1'b0;
    frames[1] = frames[0];
    frames[2].rows = '0;
    frames[2].blank = 1'b1;
    frames[3] = frames[0];
    frames[4].rows = {16'hA5A5, 16'h0420, 16'h0810, 16'h1008, 16'h2004, 16'h4002, 16'h8001, 16'hFFFF};
    frames[4].blank = 1'b0;

    ia.enable = 1'b0; ia.dinor = 8'hFF; ia.outc = '0; ia.rd_row = 3'd3; ia.err_clr = 1'b0;
    ib.enable = 1'b0; ib.dinor = 8'hFF; ib.outc = '0; ib.rd_row = 3'd3; ib.err_clr = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rd_data", 32'(ia.rd_data), 32'd0);
    check("rst_frame_done", 32'(ia.frame_done), 32'd0);
    check("rst_frame_count", 32'(ia.frame_count), 32'd0);
    check("rst_seq_err", 32'(ia.seq_err), 32'd0);
    check("rst_sel_err", 32'(ia.sel_err), 32'd0);
    check("rst_frame_blank", 32'(ia.frame_blank), 32'd0);
    rst = 1'b1;

    // Back-to-back frames from the table
    @(negedge clk);
    ia.enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      push_exp(f);
      scan(1'b0, f, 0, 7, 1);
    end
    idle(1'b0, 3);
    ia.enable = 1'b0;
    check("p1_sb_empty", 32'(sb.size()), 32'd0);
    check("p1_frame_count", 32'(ia.frame_count), 32'd5);
    check("p1_seq_err", 32'(ia.seq_err), 32'd0);
    check("p1_sel_err", 32'(ia.sel_err), 32'd0);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      ia.rd_row = 3'(r);
      @(negedge clk);
      check("readback_row", 32'(ia.rd_data), 32'(frames[4].rows[r]));
    end
    ia.rd_row = 3'd3;

    // Order error 0,1,2,5 then recovery
    @(negedge clk);
    ia.enable = 1'b1;
    idle(1'b0, 1);
    scan(1'b0, 0, 0, 2, 1);
    drv(1'b0, 8'hDF, 16'h1234);
    idle(1'b0, 3);
    check("ord_seq_err", 32'(ia.seq_err), 32'd1);
    check("ord_count_held", 32'(ia.frame_count), 32'd5);
    check("ord_buf_unchanged", 32'(ia.rd_data), 32'(frames[4].rows[3]));
    push_exp(0);
    scan(1'b0, 0, 0, 7, 1);
    idle(1'b0, 3);
    check("ord_seq_err_sticky", 32'(ia.seq_err), 32'd1);
    pulse_clr();
    check("ord_seq_err_clr", 32'(ia.seq_err), 32'd0);
    @(negedge clk);
    ia.enable = 1'b0;

    // Illegal select mid-frame still commits
    @(negedge clk);
    ia.enable = 1'b1;
    idle(1'b0, 1);
    push_exp(4);
    scan(1'b0, 4, 0, 2, 1);
    drv(1'b0, 8'hFC, 16'h0000);
    scan(1'b0, 4, 3, 7, 1);
    idle(1'b0, 3);
    check("ill_sel_err", 32'(ia.sel_err), 32'd1);
    check("ill_seq_err", 32'(ia.seq_err), 32'd0);
    check("ill_frame_count", 32'(ia.frame_count), 32'd7);
    @(negedge clk);
    ia.enable = 1'b0;
    @(negedge clk);
    ia.enable = 1'b1;
    pulse_clr();
    check("ill_sel_clr", 32'(ia.sel_err), 32'd0);
    drv(1'b0, 8'hFC, 16'h0000);
    @(negedge clk);
    check("ill_sel_latency", 32'(ia.sel_err), 32'd0);
    ia.dinor = 8'hFF;
    ia.err_clr = 1'b1;
    @(negedge clk);
    ia.err_clr = 1'b0;
    check("ill_set_beats_clr", 32'(ia.sel_err), 32'd1);
    pulse_clr();
    check("ill_sel_clr2", 32'(ia.sel_err), 32'd0);

    // Blank timeout boundary (15 tolerated, 16th trips), then back in HUNT
    scan(1'b0, 0, 0, 2, 1);
    idle(1'b0, 16);
    @(negedge clk);
    check("to_not_yet", 32'(ia.seq_err), 32'd0);
    @(negedge clk);
    check("to_seq_err", 32'(ia.seq_err), 32'd1);
    pulse_clr();
    check("to_clr", 32'(ia.seq_err), 32'd0);
    scan(1'b0, 0, 4, 5, 1);
    idle(1'b0, 2);
    check("hunt_ignores", 32'(ia.seq_err), 32'd0);
    push_exp(1);
    scan(1'b0, 1, 0, 7, 1);
    idle(1'b0, 3);
    check("to_recover_count", 32'(ia.frame_count), 32'd8);

    // Disable after row 4
    scan(1'b0, 4, 0, 4, 1);
    drv(1'b0, 8'hFF, 16'h0000);
    ia.enable = 1'b0;
    idle(1'b0, 3);
    check("dis_count_held", 32'(ia.frame_count), 32'd8);
    check("dis_buf_held", 32'(ia.rd_data), 32'(frames[1].rows[3]));
    @(negedge clk);
    ia.enable = 1'b1;
    scan(1'b0, 4, 5, 7, 1);
    idle(1'b0, 3);
    check("dis_partial_dropped", 32'(ia.frame_count), 32'd8);
    check("dis_seq_err", 32'(ia.seq_err), 32'd0);

    // Reset mid-frame with error flag and count set
    scan(1'b0, 0, 0, 1, 1);
    drv(1'b0, 8'hF7, 16'h00E0);
    idle(1'b0, 2);
    check("rst_pre_seq_err", 32'(ia.seq_err), 32'd1);
    scan(1'b0, 0, 0, 3, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_rd_data", 32'(ia.rd_data), 32'd0);
    check("mid_rst_frame_done", 32'(ia.frame_done), 32'd0);
    check("mid_rst_frame_count", 32'(ia.frame_count), 32'd0);
    check("mid_rst_seq_err", 32'(ia.seq_err), 32'd0);
    check("mid_rst_sel_err", 32'(ia.sel_err), 32'd0);
    check("mid_rst_frame_blank", 32'(ia.frame_blank), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;
    idle(1'b0, 2);
    push_exp(4);
    scan(1'b0, 4, 0, 7, 1);
    idle(1'b0, 3);
    ia.enable = 1'b0;
    check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    // SETTLE=3: 2-cycle dwell never captures, 3-cycle dwell commits every 24
    @(negedge clk);
    ib.enable = 1'b1;
    idle(1'b1, 1);
    scan(1'b1, 4, 0, 7, 2);
    scan(1'b1, 4, 0, 7, 2);
    idle(1'b1, 4);
    check("b_short_no_done", 32'(b_done_n), 32'd0);
    check("b_short_count", 32'(ib.frame_count), 32'd0);
    check("b_short_seq_err", 32'(ib.seq_err), 32'd0);
    for (int k = 0; k < 3; k++) scan(1'b1, 0, 0, 7, 3);
    idle(1'b1, 4);
    ib.enable = 1'b0;
    check("b_done_n", 32'(b_done_n), 32'd3);
    check("b_count", 32'(ib.frame_count), 32'd3);
    check("b_rd_row3", 32'(ib.rd_data), 32'(frames[0].rows[3]));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_scan_capture.md
# matrix_scan_capture

Receive-side monitor for the 8-row × 16-column LED matrix scan bus. It samples the active-low row select (`dinor`) and column data (`outc`) driven by the screen generators and rebuilds the displayed frame in an internal 8×16 buffer. Each fully scanned frame is committed atomically. The frame is readable through a registered row port, with frame-complete pulses and sticky scan-error flags. It sits beside the matrix pins for self-check, frame mirroring and bench scoreboarding.

## Interface
Parameters:
- `SETTLE`, default 1: consecutive sampled cycles a row must hold before its column data is captured (1..15).
- `BLANK_TIMEOUT`, default 16: sampled all-ones cycles tolerated mid-frame before the partial frame is dropped (1..255).

Ports:
- `clk`  in  1  scan clock, same clock as the screen generators (10 kHz).
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture enable; 0 forces IDLE.
- `dinor`  in  8  row select under observation; active-low, one-hot-zero.
- `outc`  in  16  column data under observation.
- `rd_row`  in  3  committed-frame row to read.
- `rd_data`  out  16  committed row data, registered.
- `frame_done`  out  1  one-cycle pulse when a frame commits.
- `frame_count`  out  8  committed frames, wraps 255→0.
- `seq_err`  out  1  sticky: out-of-order row or timeout observed.
- `sel_err`  out  1  sticky: illegal `dinor` code observed.
- `err_clr`  in  1  synchronous clear of both sticky flags.
- `frame_blank`  out  1  see Configuration.

## Operation
- Input stage: `dinor` and `outc` are registered once; all decode uses the registered copies.
- Decode:
  - exactly one bit 0: valid, row = index of that bit;
  - 8'hFF: blank;
  - anything else: illegal, sets `sel_err` and is treated as blank for sequencing.
- Stability counter: counts consecutive cycles of the same valid row and resets on any change. A row is captured once per dwell, on the cycle the count reaches `SETTLE`. No re-capture occurs until the row changes.
- FSM:
  - IDLE: entered when `enable`=0; shadow buffer and expected row are cleared. Moves to HUNT when `enable`=1.
  - HUNT: waits for a captured row 0. That capture writes shadow[0], sets expect=1 and moves to ACQ. Captures of other rows are ignored, with no error.
  - ACQ, capture of row == expect: write shadow[row], then expect+1.
  - ACQ, capture of row ≠ expect: set `seq_err`, drop the partial frame and go to HUNT. If the offending row is 0, it is consumed as the HUNT capture and the FSM returns to ACQ with expect=1.
  - ACQ, blank for `BLANK_TIMEOUT` consecutive cycles: set `seq_err` and go to HUNT.
  - ACQ, capture of row 7 with expect=7: copy the shadow (including row 7) to the committed buffer, pulse `frame_done`, increment `frame_count`, set expect=0 and stay in ACQ.
- Committed buffer changes only on commit. `rd_data` never shows a partial frame.
- `err_clr` clears the flags. If a new error occurs in the same cycle, the set wins.
- If `enable` falls mid-frame, the partial frame is discarded. The committed buffer, `frame_count` and the flags are retained.

## Timing
- Reset values: `rd_data`=0, `frame_done`=0, `frame_count`=0, `seq_err`=0, `sel_err`=0, `frame_blank`=0. Committed buffer is all 0 and the FSM is in IDLE.
- Capture latency (`SETTLE`=1): a row presented on the inputs in cycle t is written at the edge ending cycle t+1.
- Commit latency: for row 7 presented in cycle t, `frame_done` is high and the new data is readable in cycle t+2.
- Capture timing for `SETTLE`=N: capture happens N−1 cycles later than for `SETTLE`=1.
- Read latency: `rd_data` reflects `rd_row` one cycle later. A read in the commit cycle returns new data from the following cycle.
- `frame_done` width: exactly one cycle, even with back-to-back frames at one row per cycle, which gives one commit every 8 cycles.
- `sel_err` latency: set one cycle after the illegal code is registered.

## Configuration
- With `MATRIX_CAP_BLANK_DETECT_EN` defined, `frame_blank` is updated at each commit and is 1 when all 8 committed rows are 16'h0000.
  - It holds that value until the next commit.
  - This lets software verify blink phases.
- Without the macro, `frame_blank` is tied to 0 and the detect logic is omitted.

## Test plan
- Normal scan:
  - Stimulus: reset, `enable`=1, drive rows 0..7 with the arrow pattern (row1=16'h0080, row2=16'h00C0, row3=16'h00E0, row4=16'h00C0, row5=16'h0080, other rows 0), then repeat.
  - Response: `frame_done` pulses every 8 cycles and `frame_count` increments.
  - Readback: `rd_row`=3 returns 16'h00E0.
- Blank-phase frame:
  - Stimulus: a frame with all `outc`=0.
  - Response: committed rows all 0. With the macro, `frame_blank`=1; without it, `frame_blank`=0.
- Order error:
  - Stimulus: rows 0,1,2,5.
  - Response: `seq_err`=1, no `frame_done`, committed buffer unchanged.
  - Recovery: a following clean 0..7 scan commits, and `seq_err` stays set until `err_clr`.
- Illegal select:
  - Stimulus: `dinor`=8'hFC for one cycle mid-frame.
  - Response: `sel_err`=1 and the blank counter runs.
  - Timeout: `dinor`=8'hFF for 16 cycles causes `seq_err` and a return to HUNT.
- Mid-operation disable and reset:
  - `enable`→0 after row 4: no commit, `frame_count` held.
  - `rst` low mid-frame: all outputs return to their reset values.
- Settle filter:
  - Stimulus: `SETTLE`=3, rows held 2 cycles each.
  - Response: no captures and no `frame_done`.
  - With rows held 3 cycles each, `frame_done` pulses every 24 cycles.
